// File: rtl/gates_debounce_pkg.sv
// rtl/gates_debounce_pkg.sv - shared states, counter sizing and parameter limits for the input debouncer
// Optional status counter macro: GATES_DEBOUNCE_STATUS_EN.
package gates_debounce_pkg;

  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    S_LO      = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HI      = 2'b10,
    S_WAIT_LO = 2'b11
  } deb_state_e;

  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gates_input_debouncer_channel.sv
// rtl/gates_input_debouncer_channel.sv - one channel: synchroniser chain, qualification FSM and counter
// Optional status counter macro (used by the top only): GATES_DEBOUNCE_STATUS_EN.
module debounce_channel
  import gates_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic glitch,
  output logic in_wait
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES || SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_params
    $error("debounce_channel: DEBOUNCE_CYCLES and SYNC_STAGES must both be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    glitch  = 1'b0;
    case (state_q)
      S_LO: begin
        if (s) begin
          state_d = S_WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (!s) begin
          state_d = S_LO;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (!s) begin
          state_d = S_WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (s) begin
          state_d = S_HI;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The level follows the state register directly, so it flips on the same edge as the pulse.
  assign out     = (state_q == S_HI) || (state_q == S_WAIT_LO);
  assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: rtl/gates_input_debouncer.sv
// rtl/gates_input_debouncer.sv - two-channel switch debouncer feeding the logic-gate block
// GATES_DEBOUNCE_STATUS_EN adds the saturating glitch_cnt status output.
module gates_input_debouncer
  import gates_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_a_raw,
  input  logic       sw_b_raw,
  output logic       a,
  output logic       b,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic       stable
`ifdef GATES_DEBOUNCE_STATUS_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  logic glitch_a, glitch_b;
  logic wait_a, wait_b;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_a (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_a_raw),
    .out    (a),
    .rise   (a_rise),
    .fall   (a_fall),
    .glitch (glitch_a),
    .in_wait(wait_a)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_b (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_b_raw),
    .out    (b),
    .rise   (b_rise),
    .fall   (b_fall),
    .glitch (glitch_b),
    .in_wait(wait_b)
  );

  assign stable = !wait_a && !wait_b;

`ifdef GATES_DEBOUNCE_STATUS_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic [8:0] glitch_sum;

  // Both channels may abort together, so the step is 0, 1 or 2 before saturating.
  always_comb begin
    glitch_sum   = {1'b0, glitch_cnt_q} + 9'(glitch_a) + 9'(glitch_b);
    glitch_cnt_d = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= 8'h00;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_a ^ glitch_b;
`endif

endmodule

// File: tb/tb_gates_input_debouncer.sv
// tb/tb_gates_input_debouncer.sv - directed and randomized checks of gates_input_debouncer
// Checks glitch_cnt when GATES_DEBOUNCE_STATUS_EN is defined.
module tb_gates_input_debouncer;

  localparam int D    = 4;
  localparam int SYNC = 2;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic sw_a_raw = 1'b0;
  logic sw_b_raw = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall, stable;
`ifdef GATES_DEBOUNCE_STATUS_EN
  logic [7:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  gates_input_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_a_raw(sw_a_raw),
    .sw_b_raw(sw_b_raw),
    .a       (a),
    .b       (b),
    .a_rise  (a_rise),
    .a_fall  (a_fall),
    .b_rise  (b_rise),
    .b_fall  (b_fall),
    .stable  (stable)
`ifdef GATES_DEBOUNCE_STATUS_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference: a level is accepted after D consecutive differing samples seen SYNC edges late.
  logic m_pipe [2][SYNC];
  int   m_run  [2];
  logic m_out  [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_glitch;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < SYNC; k++) m_pipe[ch][k] = 1'b0;
      m_run[ch]  = 0;
      m_out[ch]  = 1'b0;
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
    end
    m_glitch = 0;
  endtask

  task automatic model_edge();
    logic raw [2];
    logic obs;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = sw_a_raw;
    raw[1] = sw_b_raw;
    for (int ch = 0; ch < 2; ch++) begin
      obs = m_pipe[ch][SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_pipe[ch][k] = m_pipe[ch][k-1];
      m_pipe[ch][0] = raw[ch];
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (obs !== m_out[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_out[ch]  = obs;
          m_rise[ch] = obs;
          m_fall[ch] = !obs;
          m_run[ch]  = 0;
        end
      end else if (m_run[ch] > 0) begin
        m_run[ch] = 0;
        if (m_glitch < 255) m_glitch++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_a", a, m_out[0]);
    chk("m_b", b, m_out[1]);
    chk("m_a_rise", a_rise, m_rise[0]);
    chk("m_a_fall", a_fall, m_fall[0]);
    chk("m_b_rise", b_rise, m_rise[1]);
    chk("m_b_fall", b_fall, m_fall[1]);
    chk("m_stable", stable, (m_run[0] == 0) && (m_run[1] == 0));
`ifdef GATES_DEBOUNCE_STATUS_EN
    chk("m_glitch_cnt", glitch_cnt, m_glitch[7:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int hold_a;
    int hold_b;
    hold_a = 0;
    hold_b = 0;
    model_reset();

    // Reset held with both raw inputs high
    sw_a_raw = 1'b1;
    sw_b_raw = 1'b1;
    repeat (3) begin
      step();
      chk("t1_a", a, 0);
      chk("t1_b", b, 0);
      chk("t1_pulses", a_rise | a_fall | b_rise | b_fall, 0);
      chk("t1_stable", stable, 1);
`ifdef GATES_DEBOUNCE_STATUS_EN
      chk("t1_glitch_cnt", glitch_cnt, 0);
`endif
    end
    sw_a_raw = 1'b0;
    sw_b_raw = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();

    // Short bounce on A: three edges high, then low
    sw_a_raw = 1'b1;
    repeat (3) step();
    sw_a_raw = 1'b0;
    for (int e = 4; e <= 9; e++) begin
      step();
      chk("t3_a", a, 0);
      chk("t3_a_rise", a_rise, 0);
    end
    chk("t3_stable", stable, 1);
`ifdef GATES_DEBOUNCE_STATUS_EN
    chk("t3_glitch_cnt", glitch_cnt, 1);
`endif

    // A rises and holds
    sw_a_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("t2_a", a, e >= 6);
      chk("t2_a_rise", a_rise, e == 6);
      chk("t2_stable", stable, !(e >= 3 && e <= 5));
      chk("t2_b", b, 0);
    end

    // A falls and holds
    sw_a_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("t4_a", a, e < 6);
      chk("t4_a_fall", a_fall, e == 6);
      chk("t4_a_rise", a_rise, 0);
    end

    // Both channels rise together
    sw_a_raw = 1'b1;
    sw_b_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("t5_a", a, e >= 6);
      chk("t5_b", b, e >= 6);
      chk("t5_a_rise", a_rise, e == 6);
      chk("t5_b_rise", b_rise, e == 6);
    end

    // Asynchronous reset in the middle of B's qualification
    sw_a_raw = 1'b0;
    sw_b_raw = 1'b0;
    repeat (8) step();
    sw_b_raw = 1'b1;
    repeat (4) step();
    chk("t6_stable_wait", stable, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_b_async", b, 0);
    chk("t6_stable_async", stable, 1);
`ifdef GATES_DEBOUNCE_STATUS_EN
    chk("t6_glitch_cnt_async", glitch_cnt, 0);
`endif
    step();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("t6_b", b, e >= 6);
      chk("t6_b_rise", b_rise, e == 6);
    end

    // Randomized bouncing on both channels against the reference
    repeat (800) begin
      if (hold_a == 0) begin
        sw_a_raw = 1'($urandom_range(0, 1));
        hold_a   = int'($urandom_range(1, 8));
      end
      if (hold_b == 0) begin
        sw_b_raw = 1'($urandom_range(0, 1));
        hold_b   = int'($urandom_range(1, 8));
      end
      hold_a--;
      hold_b--;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
